gradient_pattern_gen: RTL
=========================

# gradient_pattern_gen

Parametrised gray-ramp and stepped-bar pattern source for the LVDS panel pattern generator. It sits between the video timing generator and the LVDS serializer. From de_in and frame_start it produces per-pixel RGB for four modes: horizontal ramp, vertical ramp, horizontal steps and vertical steps. Output polarity and per-channel enables are selectable. Level arithmetic uses division-free incremental accumulators instead of a ROM, so resolution and depth are parameters rather than memory size.

## Interface
- H_ACTIVE, 1920, active pixels per line; ramp denominator is H_ACTIVE-1 (≥2).
- V_ACTIVE, 1080, active lines per frame; ramp denominator is V_ACTIVE-1 (≥2).
- DATA_W, 8, bits per colour channel; MAXV = 2^DATA_W-1.
- NUM_STEPS, 16, bar count in step modes; 2 ≤ NUM_STEPS ≤ min(H_ACTIVE, V_ACTIVE).
- clk  in  1  pixel clock.
- rstn  in  1  reset, asynchronous, active-low.
- frame_start  in  1  one-cycle pulse marking the first line of a frame.
- de_in  in  1  data enable from the timing generator.
- mode  in  2  0 H-ramp, 1 V-ramp, 2 H-steps, 3 V-steps.
- invert  in  1  output MAXV-value.
- ch_en  in  3  {r,g,b} enables; a disabled channel outputs 0.
- de_out  out  1  de_in delayed to align with the output pixel.
- r_out, g_out, b_out  out  DATA_W  pixel colour.

## Operation
- Config: mode, invert and ch_en are latched only on frame_start.
  - After reset the latched values are mode=0, invert=0, ch_en=3'b111.
  - Changes mid-frame are ignored until the next frame_start.
- Position: x counts de_in-high cycles within a line and clears on the de_in falling edge.
  - y increments on each de_in falling edge.
  - frame_start clears x, y and all accumulators.
  - x saturates at H_ACTIVE-1 and y saturates at V_ACTIVE-1; the value holds at saturation.
- Ramp value must equal floor(p*MAXV/(N-1)), where (p,N) is (x,H_ACTIVE) or (y,V_ACTIVE).
  - Localparams Q=MAXV/(N-1) and R=MAXV%(N-1).
  - Per advance of p: q+=Q, r+=R; if r≥N-1 then r-=N-1 and q+=1.
- Step index must equal k=floor(p*NUM_STEPS/N).
  - Per advance of p: s+=NUM_STEPS; if s≥N then s-=N and k+=1, with k capped at NUM_STEPS-1.
  - Step level must equal floor(k*MAXV/(NUM_STEPS-1)), updated by the same Q/R scheme each time k increments.
- H accumulators advance per active pixel and reset at line end. V accumulators advance per line and reset on frame_start.
- Accumulator widths: remainders use clog2(N) bits; q and level use DATA_W bits and never exceed MAXV.
- Output path:
  - value = mode-selected level.
  - If invert is set, value = MAXV-value.
  - Each channel = ch_en bit ? value : 0.
  - When de_out=0, all channels are 0.

## Timing
- Latency: 2 cycles. de_in at cycle t gives de_out and colour at t+2.
- Stage 1 registers the selected level plus de. Stage 2 applies invert/ch_en masking and registers the outputs.
- Reset values: de_out=0, r/g/b_out=0, x=y=0, all accumulators 0, latched config at its defaults. The pipeline flushes to 0 immediately.
- frame_start coincident with de_in: frame_start wins and that pixel is x=0, y=0 of the new frame under the new config.
- Reset mid-line: outputs are 0 from reset assertion. After release, pixels stay consistent with x=y=0 counting until the next frame_start.
- A de_in gap inside a line ends that line: the y increment applies.

## Test plan
- H-ramp, defaults, full 1920-pixel line: x=0→0, x=960→127, x=1919→255, monotonic non-decreasing; de_out lags de_in by exactly 2 cycles.
- V-ramp, full frame: y=0→0, y=540→127, y=1079→255; value is constant across each line.
- H-steps with NUM_STEPS=16: x=119→0, x=120→17, x=239→17, x=1919→255.
- invert=1 and ch_en=3'b010 latched at frame_start in H-ramp: at x=0, g=255 and r=b=0; at x=1919, g=0.
- Change mode 0→1 mid-frame: no output change until the next frame_start. A 2000-pixel line holds 255 from x=1919 onward.
- Assert rstn low during the 500th pixel: the next edge shows outputs 0. After release, frame_start then restores the x=0→0 ramp.

Source files
------------

// File: rtl/gradient_pattern_gen.sv
// Gray-ramp / stepped-bar pattern source with division-free level accumulators.
// Two-stage pipeline: level select, then invert/channel masking.
module gradient_pattern_gen #(
  parameter int unsigned H_ACTIVE  = 1920,
  parameter int unsigned V_ACTIVE  = 1080,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_STEPS = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              frame_start,
  input  logic              de_in,
  input  logic [1:0]        mode,
  input  logic              invert,
  input  logic [2:0]        ch_en,
  output logic              de_out,
  output logic [DATA_W-1:0] r_out,
  output logic [DATA_W-1:0] g_out,
  output logic [DATA_W-1:0] b_out
);

  localparam int unsigned MAXV = (1 << DATA_W) - 1;
  localparam int unsigned HW   = $clog2(H_ACTIVE);
  localparam int unsigned VW   = $clog2(V_ACTIVE);
  localparam int unsigned SW   = $clog2(NUM_STEPS);

  localparam logic [DATA_W-1:0] HQ    = DATA_W'(MAXV / (H_ACTIVE - 1));
  localparam logic [HW:0]       HR    = (HW+1)'(MAXV % (H_ACTIVE - 1));
  localparam logic [HW:0]       HDEN  = (HW+1)'(H_ACTIVE - 1);
  localparam logic [HW:0]       HN    = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]       HSTEP = (HW+1)'(NUM_STEPS);
  localparam logic [HW-1:0]     HLAST = HW'(H_ACTIVE - 1);

  localparam logic [DATA_W-1:0] VQ    = DATA_W'(MAXV / (V_ACTIVE - 1));
  localparam logic [VW:0]       VR    = (VW+1)'(MAXV % (V_ACTIVE - 1));
  localparam logic [VW:0]       VDEN  = (VW+1)'(V_ACTIVE - 1);
  localparam logic [VW:0]       VN    = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0]       VSTEP = (VW+1)'(NUM_STEPS);
  localparam logic [VW-1:0]     VLAST = VW'(V_ACTIVE - 1);

  localparam logic [DATA_W-1:0] SQ    = DATA_W'(MAXV / (NUM_STEPS - 1));
  localparam logic [SW:0]       SR    = (SW+1)'(MAXV % (NUM_STEPS - 1));
  localparam logic [SW:0]       SDEN  = (SW+1)'(NUM_STEPS - 1);
  localparam logic [SW-1:0]     KLAST = SW'(NUM_STEPS - 1);

  // Bar index plus its level, advanced together whenever the index steps.
  typedef struct packed {
    logic [SW-1:0]     k;
    logic [DATA_W-1:0] q;
    logic [SW-1:0]     r;
  } step_t;

  function automatic step_t step_inc(input step_t a);
    step_t       b;
    logic [SW:0] sum;
    b = a;
    if (a.k != KLAST) begin
      b.k = a.k + SW'(1);
      sum = {1'b0, a.r} + SR;
      if (sum >= SDEN) begin
        b.r = SW'(sum - SDEN);
        b.q = a.q + SQ + DATA_W'(1);
      end else begin
        b.r = sum[SW-1:0];
        b.q = a.q + SQ;
      end
    end
    return b;
  endfunction

  // Latched configuration
  logic [1:0] mode_q;
  logic       invert_q;
  logic [2:0] ch_en_q;

  // Horizontal and vertical accumulators
  logic [HW-1:0]     hx_q, hx_d, hr_q, hr_d, hs_q, hs_d;
  logic [DATA_W-1:0] hq_q, hq_d;
  step_t             hst_q, hst_d;
  logic [VW-1:0]     vy_q, vy_d, vr_q, vr_d, vs_q, vs_d;
  logic [DATA_W-1:0] vq_q, vq_d;
  step_t             vst_q, vst_d;
  logic [HW:0]       hr_sum, hs_sum;
  logic [VW:0]       vr_sum, vs_sum;

  // Pipeline
  logic              de_s1_q, inv_s1_q;
  logic [2:0]        en_s1_q;
  logic [DATA_W-1:0] lvl_s1_q, lvl_d, val;

  logic       h_clr, v_adv;
  logic [1:0] mode_e;

  // A falling de_in (seen against the stage-1 copy) ends the line.
  assign h_clr  = frame_start || (de_s1_q && !de_in);
  assign v_adv  = !frame_start && de_s1_q && !de_in && (vy_q != VLAST);
  assign mode_e = frame_start ? mode : mode_q;

  always_comb begin
    hx_d   = '0;
    hq_d   = '0;
    hr_d   = '0;
    hs_d   = '0;
    hst_d  = '0;
    hr_sum = '0;
    hs_sum = '0;
    if (!h_clr) begin
      hx_d  = hx_q;
      hq_d  = hq_q;
      hr_d  = hr_q;
      hs_d  = hs_q;
      hst_d = hst_q;
    end
    if (de_in && (hx_d != HLAST)) begin
      hx_d   = hx_d + HW'(1);
      hr_sum = {1'b0, hr_d} + HR;
      if (hr_sum >= HDEN) begin
        hr_d = HW'(hr_sum - HDEN);
        hq_d = hq_d + HQ + DATA_W'(1);
      end else begin
        hr_d = hr_sum[HW-1:0];
        hq_d = hq_d + HQ;
      end
      hs_sum = {1'b0, hs_d} + HSTEP;
      if (hs_sum >= HN) begin
        hs_d  = HW'(hs_sum - HN);
        hst_d = step_inc(hst_d);
      end else begin
        hs_d = hs_sum[HW-1:0];
      end
    end
  end

  always_comb begin
    vy_d   = vy_q;
    vq_d   = vq_q;
    vr_d   = vr_q;
    vs_d   = vs_q;
    vst_d  = vst_q;
    vr_sum = '0;
    vs_sum = '0;
    if (frame_start) begin
      vy_d  = '0;
      vq_d  = '0;
      vr_d  = '0;
      vs_d  = '0;
      vst_d = '0;
    end else if (v_adv) begin
      vy_d   = vy_q + VW'(1);
      vr_sum = {1'b0, vr_q} + VR;
      if (vr_sum >= VDEN) begin
        vr_d = VW'(vr_sum - VDEN);
        vq_d = vq_q + VQ + DATA_W'(1);
      end else begin
        vr_d = vr_sum[VW-1:0];
        vq_d = vq_q + VQ;
      end
      vs_sum = {1'b0, vs_q} + VSTEP;
      if (vs_sum >= VN) begin
        vs_d  = VW'(vs_sum - VN);
        vst_d = step_inc(vst_q);
      end else begin
        vs_d = vs_sum[VW-1:0];
      end
    end
  end

  // Level for the pixel presented this cycle, before any advance.
  always_comb begin
    lvl_d = '0;
    unique case (mode_e)
      2'd0: lvl_d = h_clr       ? '0 : hq_q;
      2'd1: lvl_d = frame_start ? '0 : vq_q;
      2'd2: lvl_d = h_clr       ? '0 : hst_q.q;
      2'd3: lvl_d = frame_start ? '0 : vst_q.q;
    endcase
  end

  assign val = inv_s1_q ? ~lvl_s1_q : lvl_s1_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q   <= 2'd0;
      invert_q <= 1'b0;
      ch_en_q  <= 3'b111;
      hx_q     <= '0;
      hq_q     <= '0;
      hr_q     <= '0;
      hs_q     <= '0;
      hst_q    <= '0;
      vy_q     <= '0;
      vq_q     <= '0;
      vr_q     <= '0;
      vs_q     <= '0;
      vst_q    <= '0;
      de_s1_q  <= 1'b0;
      inv_s1_q <= 1'b0;
      en_s1_q  <= 3'b000;
      lvl_s1_q <= '0;
      de_out   <= 1'b0;
      r_out    <= '0;
      g_out    <= '0;
      b_out    <= '0;
    end else begin
      if (frame_start) begin
        mode_q   <= mode;
        invert_q <= invert;
        ch_en_q  <= ch_en;
      end
      hx_q     <= hx_d;
      hq_q     <= hq_d;
      hr_q     <= hr_d;
      hs_q     <= hs_d;
      hst_q    <= hst_d;
      vy_q     <= vy_d;
      vq_q     <= vq_d;
      vr_q     <= vr_d;
      vs_q     <= vs_d;
      vst_q    <= vst_d;
      de_s1_q  <= de_in;
      inv_s1_q <= frame_start ? invert : invert_q;
      en_s1_q  <= frame_start ? ch_en : ch_en_q;
      lvl_s1_q <= lvl_d;
      de_out   <= de_s1_q;
      r_out    <= (de_s1_q && en_s1_q[2]) ? val : '0;
      g_out    <= (de_s1_q && en_s1_q[1]) ? val : '0;
      b_out    <= (de_s1_q && en_s1_q[0]) ? val : '0;
    end
  end

endmodule
